// File: rtl/ram_write_port_arbiter.sv
// ============================================================================
//  Module      : ram_write_port_arbiter
//  Description : Round-robin owner of the register RAM write port. After reset
//                or a clear request it writes zero to every RAM word, then
//                grants requesters one write per cycle. The winning write is
//                registered onto the RAM write-port pins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_write_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [NUM_REQ-1:0]               iReqValid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    iReqAddress,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    iReqData,
    output logic [NUM_REQ-1:0]               oReqReady,
    input  logic                             iClearStart,
    output logic                             oWriteEnable,
    output logic [ADDR_WIDTH-1:0]            oWriteAddress,
    output logic [DATA_WIDTH-1:0]            oWriteData,
    output logic                             oInitDone,
    output logic                             oAddrError
);

    localparam int                    c_ptr_w     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [c_ptr_w-1:0]    c_last_req  = c_ptr_w'(NUM_REQ - 1);
    localparam logic [ADDR_WIDTH:0]   c_mem_size  = (ADDR_WIDTH+1)'(MEM_SIZE);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_clear_cnt;
    logic [c_ptr_w-1:0]      r_ptr;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_init_done;
    logic                    r_addr_err;

    logic [c_ptr_w-1:0]      w_win;
    logic [c_ptr_w-1:0]      w_cand;
    logic                    w_any;
    logic                    w_grant_en;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_in_range;
    logic [c_ptr_w-1:0]      w_ptr_next;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_win  = '0;
        w_cand = '0;
        w_any  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = c_ptr_w'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_any && iReqValid[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    // A grant is only issued in RUN, and never in the cycle a clear is requested.
    assign w_grant_en = (r_state == S_RUN) && !iClearStart && w_any;
    assign w_ptr_next = (w_win == c_last_req) ? '0 : w_win + 1'b1;

    // One-hot ready to the winner, plus a mux of the winner's address and data.
    always_comb begin
        oReqReady  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (c_ptr_w'(k) == w_win) begin
                w_sel_addr = iReqAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = iReqData[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (w_grant_en) begin
            oReqReady[w_win] = 1'b1;
        end
    end

    // Out-of-range addresses still complete the handshake but are not written.
    assign w_in_range = ({1'b0, w_sel_addr} < c_mem_size);

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: CLEAR ends on the edge issuing the last word; RUN leaves on a clear request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_CLEAR: if (r_clear_cnt == c_last_addr) w_next_state = S_RUN;
            S_RUN:   if (iClearStart)                w_next_state = S_CLEAR;
            default: w_next_state = S_CLEAR;
        endcase
    end

    // Clear counter, arbitration pointer and the registered RAM write port.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_clear_cnt <= '0;
            r_ptr       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_init_done <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_init_done <= (w_next_state == S_RUN);
            r_addr_err  <= 1'b0;
            r_we        <= 1'b0;
            if (r_state == S_CLEAR) begin
                r_we        <= 1'b1;
                r_addr      <= r_clear_cnt;
                r_data      <= '0;
                r_clear_cnt <= r_clear_cnt + 1'b1;
            end else if (iClearStart) begin
                r_clear_cnt <= '0;
            end else if (w_grant_en) begin
                r_ptr <= w_ptr_next;
                if (w_in_range) begin
                    r_we   <= 1'b1;
                    r_addr <= w_sel_addr;
                    r_data <= w_sel_data;
                end else begin
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

    assign oWriteEnable  = r_we;
    assign oWriteAddress = r_addr;
    assign oWriteData    = r_data;
    assign oInitDone     = r_init_done;
    assign oAddrError    = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_write_port_arbiter.sv
// ============================================================================
//  Module      : tb_ram_write_port_arbiter
//  Description : Directed, table-driven bench for ram_write_port_arbiter with
//                hand-written clear, clear-request and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_write_port_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  iReqValid;
    logic [31:0] iReqAddress;
    logic [63:0] iReqData;
    logic [3:0]  oReqReady;
    logic        iClearStart;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [15:0] oWriteData;
    logic        oInitDone;
    logic        oAddrError;

    int total = 0;
    int bad   = 0;

    ram_write_port_arbiter #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .MEM_SIZE   (8),
        .NUM_REQ    (4)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iReqValid     (iReqValid),
        .iReqAddress   (iReqAddress),
        .iReqData      (iReqData),
        .oReqReady     (oReqReady),
        .iClearStart   (iClearStart),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oWriteData    (oWriteData),
        .oInitDone     (oInitDone),
        .oAddrError    (oAddrError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  ready;
        logic        we;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic        err;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expects to be entered in the low phase before the first clear edge;
    // returns at the negedge after the eighth clear write.
    task automatic check_clear(input int pulse_at);
        for (int i = 0; i < 8; i++) begin
            if (i == pulse_at) iClearStart = 1'b1;
            #1;
            chk($sformatf("clear%0d ready", i), 64'(oReqReady), 64'h0);
            @(posedge Clock); #1;
            iClearStart = 1'b0;
            chk($sformatf("clear%0d we", i),   64'(oWriteEnable),  64'h1);
            chk($sformatf("clear%0d addr", i), 64'(oWriteAddress), 64'(i));
            chk($sformatf("clear%0d data", i), 64'(oWriteData),    64'h0);
            chk($sformatf("clear%0d init", i), 64'(oInitDone),     64'(i == 7));
            @(negedge Clock);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] AP = {8'd7, 8'd6, 8'd5, 8'd4};
    localparam logic [63:0] DP = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

    initial begin
        vecs[0]  = '{4'b0010, {8'd0, 8'd0, 8'd3, 8'd0},   {16'h0, 16'h0, 16'hBEEF, 16'h0},       4'b0010, 1'b1, 8'd3, 16'hBEEF, 1'b0};
        vecs[1]  = '{4'b1000, {8'd2, 8'd0, 8'd0, 8'd0},   {16'h3333, 16'h0, 16'h0, 16'h0},       4'b1000, 1'b1, 8'd2, 16'h3333, 1'b0};
        vecs[2]  = '{4'b0000, 32'h0, 64'h0,                                                       4'b0000, 1'b0, 8'd2, 16'h3333, 1'b0};
        vecs[3]  = '{4'b1111, AP, DP, 4'b0001, 1'b1, 8'd4, 16'hD000, 1'b0};
        vecs[4]  = '{4'b1111, AP, DP, 4'b0010, 1'b1, 8'd5, 16'hD001, 1'b0};
        vecs[5]  = '{4'b1111, AP, DP, 4'b0100, 1'b1, 8'd6, 16'hD002, 1'b0};
        vecs[6]  = '{4'b1111, AP, DP, 4'b1000, 1'b1, 8'd7, 16'hD003, 1'b0};
        vecs[7]  = '{4'b1111, AP, DP, 4'b0001, 1'b1, 8'd4, 16'hD000, 1'b0};
        vecs[8]  = '{4'b1111, AP, DP, 4'b0010, 1'b1, 8'd5, 16'hD001, 1'b0};
        vecs[9]  = '{4'b0100, {8'd0, 8'd8, 8'd0, 8'd0},   {16'h0, 16'h7777, 16'h0, 16'h0},       4'b0100, 1'b0, 8'd5, 16'hD001, 1'b1};
        vecs[10] = '{4'b0000, 32'h0, 64'h0,                                                       4'b0000, 1'b0, 8'd5, 16'hD001, 1'b0};
        vecs[11] = '{4'b0101, {8'd0, 8'd6, 8'd0, 8'd1},   {16'h0, 16'h5678, 16'h0, 16'h1234},    4'b0001, 1'b1, 8'd1, 16'h1234, 1'b0};
        vecs[12] = '{4'b0101, {8'd0, 8'd6, 8'd0, 8'd1},   {16'h0, 16'h5678, 16'h0, 16'h1234},    4'b0100, 1'b1, 8'd6, 16'h5678, 1'b0};
        vecs[13] = '{4'b0000, 32'h0, 64'h0,                                                       4'b0000, 1'b0, 8'd6, 16'h5678, 1'b0};
        vecs[14] = '{4'b1000, {8'd7, 8'd0, 8'd0, 8'd0},   {16'hFFFF, 16'h0, 16'h0, 16'h0},       4'b1000, 1'b1, 8'd7, 16'hFFFF, 1'b0};
        vecs[15] = '{4'b0010, {8'd0, 8'd0, 8'd255, 8'd0}, {16'h0, 16'h0, 16'hEEEE, 16'h0},       4'b0010, 1'b0, 8'd7, 16'hFFFF, 1'b1};
        vecs[16] = '{4'b0000, 32'h0, 64'h0,                                                       4'b0000, 1'b0, 8'd7, 16'hFFFF, 1'b0};

        // Reset state, with every requester asking.
        Reset       = 1'b0;
        iClearStart = 1'b0;
        iReqValid   = 4'b1111;
        iReqAddress = AP;
        iReqData    = DP;
        #12;
        chk("rst we",    64'(oWriteEnable),  64'h0);
        chk("rst addr",  64'(oWriteAddress), 64'h0);
        chk("rst data",  64'(oWriteData),    64'h0);
        chk("rst init",  64'(oInitDone),     64'h0);
        chk("rst err",   64'(oAddrError),    64'h0);
        chk("rst ready", 64'(oReqReady),     64'h0);

        // Power-up clear, then the first RUN cycle grants requester 0.
        @(negedge Clock);
        Reset = 1'b1;
        check_clear(-1);
        #1;
        chk("run0 ready", 64'(oReqReady), 64'b0001);
        iReqValid = 4'b0000;

        // Table-driven RUN vectors: ready checked in-cycle, write port one edge later.
        for (int i = 0; i < 17; i++) begin
            @(negedge Clock);
            iReqValid   = vecs[i].valid;
            iReqAddress = vecs[i].addr;
            iReqData    = vecs[i].data;
            #2;
            chk($sformatf("v%0d ready", i), 64'(oReqReady), 64'(vecs[i].ready));
            @(posedge Clock); #1;
            chk($sformatf("v%0d we", i),   64'(oWriteEnable), 64'(vecs[i].we));
            chk($sformatf("v%0d err", i),  64'(oAddrError),   64'(vecs[i].err));
            chk($sformatf("v%0d init", i), 64'(oInitDone),    64'h1);
            if (vecs[i].we || vecs[i].err || i == 2 || i == 16) begin
                chk($sformatf("v%0d addr", i), 64'(oWriteAddress), 64'(vecs[i].waddr));
                chk($sformatf("v%0d data", i), 64'(oWriteData),    64'(vecs[i].wdata));
            end
        end

        // Grant in the last RUN cycle before a clear is still presented.
        @(negedge Clock);
        iReqValid   = 4'b0001;
        iReqAddress = {8'd0, 8'd0, 8'd0, 8'd3};
        iReqData    = {16'h0, 16'h0, 16'h0, 16'hAAAA};
        #1;
        chk("pre-clr ready", 64'(oReqReady), 64'b0001);
        @(posedge Clock); #1;
        chk("pre-clr we",   64'(oWriteEnable),  64'h1);
        chk("pre-clr addr", 64'(oWriteAddress), 64'h3);
        chk("pre-clr data", 64'(oWriteData),    64'hAAAA);

        // Clear request with req0 pending: no grant that cycle, then a full clear.
        @(negedge Clock);
        iClearStart = 1'b1;
        iReqData    = {16'h0, 16'h0, 16'h0, 16'h5555};
        #1;
        chk("clr ready", 64'(oReqReady), 64'h0);
        @(posedge Clock); #1;
        chk("clr we",   64'(oWriteEnable), 64'h0);
        chk("clr init", 64'(oInitDone),    64'h0);
        @(negedge Clock);
        iClearStart = 1'b0;
        check_clear(2);
        #1;
        chk("post-clr ready", 64'(oReqReady), 64'b0001);
        @(posedge Clock); #1;
        chk("post-clr we",   64'(oWriteEnable),  64'h1);
        chk("post-clr addr", 64'(oWriteAddress), 64'h3);
        chk("post-clr data", 64'(oWriteData),    64'h5555);

        // Reset in the middle of a clear aborts it and resets the pointer.
        @(negedge Clock);
        iReqValid   = 4'b0000;
        iClearStart = 1'b1;
        @(posedge Clock); #1;
        @(negedge Clock);
        iClearStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); #1;
            chk($sformatf("mid%0d addr", i), 64'(oWriteAddress), 64'(i));
            @(negedge Clock);
        end
        iReqValid = 4'b1111;
        Reset     = 1'b0;
        #1;
        chk("mid rst we",    64'(oWriteEnable),  64'h0);
        chk("mid rst addr",  64'(oWriteAddress), 64'h0);
        chk("mid rst init",  64'(oInitDone),     64'h0);
        chk("mid rst ready", 64'(oReqReady),     64'h0);
        @(posedge Clock); #1;
        chk("mid rst hold we", 64'(oWriteEnable), 64'h0);
        @(negedge Clock);
        Reset = 1'b1;
        check_clear(-1);
        #1;
        chk("after rst ptr", 64'(oReqReady), 64'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
